// File: rtl/rsa_roundtrip_check.sv
`default_nettype none
// ============================================================================
// Module      : rsa_roundtrip_check (with RL_binary exponentiation core)
// Description : Encrypts msg with e, decrypts the ciphertext with d on one
//               shared modular-exponentiation core, and reports good/bad.
//               Per-phase watchdog and start-to-verdict latency counter.
// Revision    : 1.0 - initial release
// ============================================================================

// Right-to-left binary modular exponentiation: always scans all 32 exponent
// bits, so latency is fixed at 32 cycles after start, then a 1-cycle end pulse.
module RL_binary (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic [31:0] base_i,
    input  logic [31:0] exp_i,
    input  logic [31:0] mod_i,
    output logic [31:0] r_o,
    output logic        end_o
);
    logic [31:0] r_q, b_q, e_q, m_q;
    logic [4:0]  cnt_q;
    logic        run_q, end_q;
    logic [31:0] w_rb, w_bb;

    // Modular products for the accumulator and the running square
    always_comb begin
        w_rb = 32'((64'(r_q) * 64'(b_q)) % 64'(m_q));
        w_bb = 32'((64'(b_q) * 64'(b_q)) % 64'(m_q));
    end

    // Exponent scan; operands are below the modulus so the base loads directly
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q   <= 32'd0;
            b_q   <= 32'd0;
            e_q   <= 32'd0;
            m_q   <= 32'd0;
            cnt_q <= 5'd0;
            run_q <= 1'b0;
            end_q <= 1'b0;
        end else begin
            end_q <= 1'b0;
            if (start_i) begin
                r_q   <= 32'd1;
                b_q   <= base_i;
                e_q   <= exp_i;
                m_q   <= mod_i;
                cnt_q <= 5'd0;
                run_q <= 1'b1;
            end else if (run_q) begin
                if (e_q[0]) begin
                    r_q <= w_rb;
                end
                b_q   <= w_bb;
                e_q   <= e_q >> 1;
                cnt_q <= cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    run_q <= 1'b0;
                    end_q <= 1'b1;
                end
            end
        end
    end

    assign r_o   = r_q;
    assign end_o = end_q;
endmodule

module rsa_roundtrip_check #(
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic [31:0] msg_i,
    input  logic [31:0] e_i,
    input  logic [31:0] d_i,
    input  logic [31:0] n_i,
    output logic        busy_o,
    output logic        good_o,
    output logic        bad_o,
    output logic        err_arg_o,
    output logic        timeout_o,
    output logic [31:0] cipher_o,
    output logic [31:0] plain_o,
    output logic [31:0] cycles_o
);
    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CHK_ARG  = 3'd1;
    localparam logic [2:0] c_ENC_GO   = 3'd2;
    localparam logic [2:0] c_ENC_WAIT = 3'd3;
    localparam logic [2:0] c_DEC_GO   = 3'd4;
    localparam logic [2:0] c_DEC_WAIT = 3'd5;
    localparam logic [2:0] c_CMP      = 3'd6;
    localparam logic [2:0] c_DONE     = 3'd7;

    localparam logic [20:0] c_WD_LIMIT = 21'(TIMEOUT_CYC - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] msg_q, e_q, d_q, n_q;
    logic        good_q, bad_q, err_arg_q, timeout_q;
    logic [31:0] cipher_q, plain_q, cycles_q;
    logic [20:0] wd_q;
    logic        core_start_q, end_prev_q;
    logic [31:0] core_base_q, core_exp_q, core_mod_q;
    logic [31:0] core_r;
    logic        core_end;
    logic        w_accept, w_arg_bad, w_end, w_wd_exp, w_busy;

    RL_binary u_core (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (core_start_q),
        .base_i  (core_base_q),
        .exp_i   (core_exp_q),
        .mod_i   (core_mod_q),
        .r_o     (core_r),
        .end_o   (core_end)
    );

    assign w_accept  = start_i && ((state_q == c_IDLE) || (state_q == c_DONE));
    assign w_arg_bad = (n_q < 32'd2) || (msg_q >= n_q) || (e_q == 32'd0) || (d_q == 32'd0);
    // Only the first high cycle of end counts
    assign w_end     = core_end && !end_prev_q;
    assign w_wd_exp  = (wd_q == c_WD_LIMIT);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= c_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE, c_DONE: if (w_accept) state_d = c_CHK_ARG;
            c_CHK_ARG:      state_d = w_arg_bad ? c_DONE : c_ENC_GO;
            c_ENC_GO:       state_d = c_ENC_WAIT;
            c_ENC_WAIT: begin
                if (w_end)         state_d = c_DEC_GO;
                else if (w_wd_exp) state_d = c_DONE;
            end
            c_DEC_GO:       state_d = c_DEC_WAIT;
            c_DEC_WAIT: begin
                if (w_end)         state_d = c_CMP;
                else if (w_wd_exp) state_d = c_DONE;
            end
            c_CMP:          state_d = c_DONE;
            default:        state_d = c_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        w_busy = (state_q != c_IDLE) && (state_q != c_DONE);
    end

    // Datapath: operand latches, sticky flags, captures, watchdog, latency
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            msg_q        <= 32'd0;
            e_q          <= 32'd0;
            d_q          <= 32'd0;
            n_q          <= 32'd0;
            good_q       <= 1'b0;
            bad_q        <= 1'b0;
            err_arg_q    <= 1'b0;
            timeout_q    <= 1'b0;
            cipher_q     <= 32'd0;
            plain_q      <= 32'd0;
            cycles_q     <= 32'd0;
            wd_q         <= 21'd0;
            core_start_q <= 1'b0;
            core_base_q  <= 32'd0;
            core_exp_q   <= 32'd0;
            core_mod_q   <= 32'd0;
            end_prev_q   <= 1'b0;
        end else begin
            end_prev_q <= core_end;
            if (w_accept) begin
                msg_q     <= msg_i;
                e_q       <= e_i;
                d_q       <= d_i;
                n_q       <= n_i;
                good_q    <= 1'b0;
                bad_q     <= 1'b0;
                err_arg_q <= 1'b0;
                timeout_q <= 1'b0;
                cipher_q  <= 32'd0;
                plain_q   <= 32'd0;
                cycles_q  <= 32'd0;
            end else if (w_busy && (cycles_q != 32'hFFFF_FFFF)) begin
                cycles_q <= cycles_q + 32'd1;
            end

            case (state_q)
                c_CHK_ARG: begin
                    if (w_arg_bad) begin
                        err_arg_q <= 1'b1;
                        bad_q     <= 1'b1;
                    end
                end
                c_ENC_GO, c_DEC_GO: wd_q <= 21'd0;
                c_ENC_WAIT, c_DEC_WAIT: begin
                    if (w_end) begin
                        if (state_q == c_ENC_WAIT) cipher_q <= core_r;
                        else                       plain_q  <= core_r;
                    end else if (w_wd_exp) begin
                        timeout_q <= 1'b1;
                        bad_q     <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 21'd1;
                    end
                end
                c_CMP: begin
                    if (plain_q == msg_q) good_q <= 1'b1;
                    else                  bad_q  <= 1'b1;
                end
                default: ;
            endcase

            // Operands are loaded on entry to a GO state and held until the next GO
            core_start_q <= (state_d == c_ENC_GO) || (state_d == c_DEC_GO);
            if (state_d == c_ENC_GO) begin
                core_base_q <= msg_q;
                core_exp_q  <= e_q;
                core_mod_q  <= n_q;
            end else if (state_d == c_DEC_GO) begin
                core_base_q <= core_r;
                core_exp_q  <= d_q;
                core_mod_q  <= n_q;
            end
        end
    end

    assign busy_o    = w_busy;
    assign good_o    = good_q;
    assign bad_o     = bad_q;
    assign err_arg_o = err_arg_q;
    assign timeout_o = timeout_q;
    assign cipher_o  = cipher_q;
    assign plain_o   = plain_q;
    assign cycles_o  = cycles_q;
endmodule
`default_nettype wire

// File: tb/tb_rsa_roundtrip_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_roundtrip_check
// Description : Scoreboard bench for rsa_roundtrip_check; a second instance
//               with a short watchdog exercises the timeout path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_roundtrip_check;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        startb = 1'b0;
    logic [31:0] msg = 32'd0, e = 32'd0, d = 32'd0, n = 32'd0;

    logic        busy, good, bad, err_arg, timeout;
    logic [31:0] cipher, plain, cycles;
    logic        b_busy, b_good, b_bad, b_err_arg, b_timeout;
    logic [31:0] b_cipher, b_plain, b_cycles;

    rsa_roundtrip_check dut (
        .clk(clk), .rstn(rstn), .start_i(start),
        .msg_i(msg), .e_i(e), .d_i(d), .n_i(n),
        .busy_o(busy), .good_o(good), .bad_o(bad), .err_arg_o(err_arg),
        .timeout_o(timeout), .cipher_o(cipher), .plain_o(plain), .cycles_o(cycles)
    );

    rsa_roundtrip_check #(.TIMEOUT_CYC(16)) dut_to (
        .clk(clk), .rstn(rstn), .start_i(startb),
        .msg_i(msg), .e_i(e), .d_i(d), .n_i(n),
        .busy_o(b_busy), .good_o(b_good), .bad_o(b_bad), .err_arg_o(b_err_arg),
        .timeout_o(b_timeout), .cipher_o(b_cipher), .plain_o(b_plain), .cycles_o(b_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        good, bad, err, to;
        logic        chk_cipher;
        logic [31:0] cipher;
        logic [1:0]  pmode;     // 0: ignore, 1: equal, 2: not equal
        logic [31:0] plain;
        logic        no_core;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: on each verdict (busy falling) pop and compare
    logic prev_busy = 1'b0;
    int   busy_cnt = 0;
    logic core_seen = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
            core_seen = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                busy_cnt  = 0;
                core_seen = 1'b0;
            end
            if (busy) busy_cnt++;
            if (dut.core_start_q) core_seen = 1'b1;
            if (prev_busy && !busy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_verdict: got verdict with empty scoreboard, required none");
                end else begin
                    exp_t x;
                    x = sb_q.pop_front();
                    chk("good", {31'd0, good}, {31'd0, x.good});
                    chk("bad", {31'd0, bad}, {31'd0, x.bad});
                    chk("err_arg", {31'd0, err_arg}, {31'd0, x.err});
                    chk("timeout", {31'd0, timeout}, {31'd0, x.to});
                    chk("cycles", cycles, busy_cnt);
                    if (x.chk_cipher) chk("cipher", cipher, x.cipher);
                    if (x.pmode == 2'd1) chk("plain", plain, x.plain);
                    if (x.pmode == 2'd2) begin
                        checks++;
                        if (plain == x.plain) begin
                            errors++;
                            $display("FAIL plain_ne: got %0d, required any value other than %0d", plain, x.plain);
                        end
                    end
                    if (x.no_core) chk("core_start_seen", {31'd0, core_seen}, 32'd0);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic push(input logic g, b, er, t, cc, input logic [31:0] c,
                        input logic [1:0] pm, input logic [31:0] p, input logic nc);
        exp_t x;
        x.good = g; x.bad = b; x.err = er; x.to = t;
        x.chk_cipher = cc; x.cipher = c; x.pmode = pm; x.plain = p; x.no_core = nc;
        sb_q.push_back(x);
    endtask

    task automatic issue(input logic [31:0] m, ee, dd, nn);
        @(negedge clk);
        msg = m; e = ee; d = dd; n = nn; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_wait: busy=1 after 500 cycles, required 0", tag);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_good", {31'd0, good}, 32'd0);
        chk("rst_bad", {31'd0, bad}, 32'd0);
        chk("rst_cipher", cipher, 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        #12 rstn = 1'b1;

        // Nominal round trip
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2790, 2'd1, 32'd65, 1'b0);
        issue(32'd65, 32'd17, 32'd2753, 32'd3233);
        wait_idle("nominal");

        // Wrong private exponent
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2790, 2'd2, 32'd65, 1'b0);
        issue(32'd65, 32'd17, 32'd2752, 32'd3233);
        wait_idle("wrong_d");

        // Argument errors: verdict two cycles after the start cycle, no core start
        push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 2'd1, 32'd0, 1'b1);
        issue(32'd3233, 32'd17, 32'd2753, 32'd3233);
        chk("arg_msg_busy", {31'd0, busy}, 32'd1);
        chk("arg_msg_early", {31'd0, err_arg}, 32'd0);
        @(negedge clk);
        chk("arg_msg_err", {31'd0, err_arg}, 32'd1);
        wait_idle("arg_msg");

        push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 2'd1, 32'd0, 1'b1);
        issue(32'd0, 32'd17, 32'd2753, 32'd1);
        @(negedge clk);
        chk("arg_n_err", {31'd0, err_arg}, 32'd1);
        wait_idle("arg_n");

        push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 2'd1, 32'd0, 1'b1);
        issue(32'd65, 32'd0, 32'd2753, 32'd3233);
        @(negedge clk);
        chk("arg_e_err", {31'd0, err_arg}, 32'd1);
        wait_idle("arg_e");

        // Starts during ENC_WAIT and DEC_WAIT are ignored
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2790, 2'd1, 32'd65, 1'b0);
        issue(32'd65, 32'd17, 32'd2753, 32'd3233);
        repeat (10) @(negedge clk);
        issue(32'd5, 32'd3, 32'd7, 32'd11);
        repeat (35) @(negedge clk);
        issue(32'd2, 32'd5, 32'd9, 32'd13);
        wait_idle("ignored_start");

        // Restart from DONE with msg=0
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 2'd1, 32'd0, 1'b0);
        issue(32'd0, 32'd17, 32'd2753, 32'd3233);
        wait_idle("msg_zero");

        // Asynchronous reset in the middle of DEC_WAIT
        issue(32'd65, 32'd17, 32'd2753, 32'd3233);
        repeat (50) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_good", {31'd0, good}, 32'd0);
        chk("arst_bad", {31'd0, bad}, 32'd0);
        chk("arst_err", {31'd0, err_arg}, 32'd0);
        chk("arst_to", {31'd0, timeout}, 32'd0);
        chk("arst_cipher", cipher, 32'd0);
        chk("arst_plain", plain, 32'd0);
        chk("arst_cycles", cycles, 32'd0);
        @(negedge clk);
        #3 rstn = 1'b1;
        repeat (40) @(negedge clk);
        chk("arst_quiet_good", {31'd0, good}, 32'd0);
        chk("arst_quiet_cipher", cipher, 32'd0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2790, 2'd1, 32'd65, 1'b0);
        issue(32'd65, 32'd17, 32'd2753, 32'd3233);
        wait_idle("after_reset");

        // Watchdog on the short-timeout instance: the core needs 33 WAIT cycles
        @(negedge clk);
        msg = 32'd65; e = 32'd17; d = 32'd2753; n = 32'd3233; startb = 1'b1;
        @(negedge clk);
        startb = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            if (k == 17) begin
                chk("to_early_timeout", {31'd0, b_timeout}, 32'd0);
                chk("to_early_busy", {31'd0, b_busy}, 32'd1);
            end
        end
        chk("to_timeout", {31'd0, b_timeout}, 32'd1);
        chk("to_bad", {31'd0, b_bad}, 32'd1);
        chk("to_busy", {31'd0, b_busy}, 32'd0);
        chk("to_cycles", b_cycles, 32'd18);
        repeat (40) @(negedge clk);
        chk("to_late_good", {31'd0, b_good}, 32'd0);
        chk("to_late_bad", {31'd0, b_bad}, 32'd1);
        chk("to_late_timeout", {31'd0, b_timeout}, 32'd1);
        chk("to_late_cipher", b_cipher, 32'd0);
        chk("to_late_busy", {31'd0, b_busy}, 32'd0);
        chk("to_late_err", {31'd0, b_err_arg}, 32'd0);
        chk("to_late_plain", b_plain, 32'd0);

        chk("sb_left", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
